mem_access_ctrl: RTL

Load/store sequencer and two-port arbiter in front of the byte-addressable RV32I data memory in the multicycle core. It accepts requests from the core's load/store stage and from a debug/program-loader port, and grants one at a time. It decodes RV32I funct3 into the memory's width strobes and checks alignment and range. It sign- or zero-extends load data and returns it with a one-cycle acknowledge.

---
 rtl/mem_access_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer and core/debug arbiter in front of the byte-addressable RV32I data memory.
// Grants one request at a time, checks width/alignment/range, and extends load data.
module mem_access_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [2:0]       core_funct3,
  input  logic [31:0]      core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic             core_ack,
  output logic [WIDTH-1:0] core_rdata,
  output logic             core_fault,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic             dbg_ack,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             dbg_fault,
  output logic [DEPTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic             mem_one_byte,
  output logic             mem_two_bytes,
  output logic             mem_four_bytes,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e     state;
  logic       last_grant;  // 1 = dbg was granted last
  logic       grant_dbg;
  logic       req_we;
  logic [2:0] req_funct3;

  logic             pick_dbg;
  logic             sel_req;
  logic             sel_we;
  logic [2:0]       sel_funct3;
  logic [31:0]      sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             sel_fault;
  logic [WIDTH-1:0] ext_rdata;

  always_comb begin
    // Core wins a tie unless it was the last one granted.
    pick_dbg   = dbg_req && (!core_req || !last_grant);
    sel_req    = core_req || dbg_req;
    sel_we     = pick_dbg ? dbg_we : core_we;
    sel_funct3 = pick_dbg ? 3'b010 : core_funct3;
    sel_addr   = pick_dbg ? dbg_addr : core_addr;
    sel_wdata  = pick_dbg ? dbg_wdata : core_wdata;
    sel_fault  = (sel_funct3 == 3'b011) || (sel_funct3 == 3'b110) || (sel_funct3 == 3'b111) ||
                 (sel_we && sel_funct3[2]) ||
                 ((sel_funct3[1:0] == 2'b01) && sel_addr[0]) ||
                 ((sel_funct3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00)) ||
                 (sel_addr[31:DEPTH] != '0);
  end

  always_comb begin
    ext_rdata = mem_rdata;
    unique case (req_funct3)
      3'b000:  ext_rdata = {{(WIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  ext_rdata = {{(WIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  ext_rdata = {{(WIDTH-8){1'b0}}, mem_rdata[7:0]};
      3'b101:  ext_rdata = {{(WIDTH-16){1'b0}}, mem_rdata[15:0]};
      default: ext_rdata = mem_rdata;
    endcase
  end

  assign busy = (state != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= StIdle;
      last_grant     <= 1'b1;
      grant_dbg      <= 1'b0;
      req_we         <= 1'b0;
      req_funct3     <= 3'b000;
      core_ack       <= 1'b0;
      core_fault     <= 1'b0;
      core_rdata     <= '0;
      dbg_ack        <= 1'b0;
      dbg_fault      <= 1'b0;
      dbg_rdata      <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wr         <= 1'b0;
      mem_rd         <= 1'b0;
      mem_one_byte   <= 1'b0;
      mem_two_bytes  <= 1'b0;
      mem_four_bytes <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (sel_req) begin
            last_grant <= pick_dbg;
            grant_dbg  <= pick_dbg;
            req_we     <= sel_we;
            req_funct3 <= sel_funct3;
            if (sel_fault) begin
              // Rejected accesses skip the memory entirely.
              state      <= StDone;
              core_ack   <= !pick_dbg;
              core_fault <= !pick_dbg;
              dbg_ack    <= pick_dbg;
              dbg_fault  <= pick_dbg;
            end else begin
              state          <= StAccess;
              mem_addr       <= sel_addr[DEPTH-1:0];
              mem_wdata      <= sel_wdata;
              mem_wr         <= sel_we;
              mem_rd         <= !sel_we;
              mem_one_byte   <= (sel_funct3[1:0] == 2'b00);
              mem_two_bytes  <= (sel_funct3[1:0] == 2'b01);
              mem_four_bytes <= (sel_funct3[1:0] == 2'b10);
            end
          end
        end
        StAccess: begin
          state          <= StDone;
          mem_addr       <= '0;
          mem_wdata      <= '0;
          mem_wr         <= 1'b0;
          mem_rd         <= 1'b0;
          mem_one_byte   <= 1'b0;
          mem_two_bytes  <= 1'b0;
          mem_four_bytes <= 1'b0;
          core_ack       <= !grant_dbg;
          dbg_ack        <= grant_dbg;
          if (!req_we) begin
            if (grant_dbg) dbg_rdata <= ext_rdata;
            else           core_rdata <= ext_rdata;
          end
        end
        StDone: begin
          state      <= StIdle;
          core_ack   <= 1'b0;
          core_fault <= 1'b0;
          core_rdata <= '0;
          dbg_ack    <= 1'b0;
          dbg_fault  <= 1'b0;
          dbg_rdata  <= '0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
